// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine: FSM state encoding,
// accumulator sizing and signed saturation.
package matvec_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_VEC = 2'd1,
      FETCH    = 2'd2,
      EMIT     = 2'd3
   } state_t;

   // Working width used by the saturation helper; wide enough for any
   // accumulator this engine is expected to be configured with.
   localparam int SAT_W = 64;

   // Accumulator must hold MAX_COLS full-precision products without overflow.
   function automatic int acc_width(input int data_width, input int max_cols);
      return 2 * data_width + $clog2(max_cols);
   endfunction

   // Clamp a signed value to the range of a signed integer of 'width' bits.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] value,
                                                        input int width);
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = 1;
      hi  = (one <<< (width - 1)) - one;
      lo  = -(one <<< (width - 1));
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/matvec_chunk_mac.sv
// One chunk of the dot product: BANDWIDTH signed lane products, lanes outside
// the valid mask forced to zero, summed into an accumulator-width result.
module matvec_chunk_mac #(
   parameter int BANDWIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 38
) (
   input  logic [BANDWIDTH*DATA_WIDTH-1:0] matrix_lanes,
   input  logic [BANDWIDTH*DATA_WIDTH-1:0] vector_lanes,
   input  logic [BANDWIDTH-1:0]            lane_mask,
   output logic signed [ACC_WIDTH-1:0]     sum
);

   localparam int PROD_W = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] a_lane [BANDWIDTH];
   logic signed [DATA_WIDTH-1:0] b_lane [BANDWIDTH];
   logic signed [PROD_W-1:0]     prod   [BANDWIDTH];
   logic signed [ACC_WIDTH-1:0]  prod_ext [BANDWIDTH];

   // Per-lane signed products, sign-extended to accumulator width; masked lanes read as 0.
   always_comb begin
      for (int j = 0; j < BANDWIDTH; j++) begin
         a_lane[j]   = signed'(matrix_lanes[j*DATA_WIDTH +: DATA_WIDTH]);
         b_lane[j]   = signed'(vector_lanes[j*DATA_WIDTH +: DATA_WIDTH]);
         prod[j]     = a_lane[j] * b_lane[j];
         prod_ext[j] = lane_mask[j] ? {{(ACC_WIDTH-PROD_W){prod[j][PROD_W-1]}}, prod[j]}
                                    : '0;
      end
   end

   // Sum of all lane products.
   always_comb begin
      sum = '0;
      for (int j = 0; j < BANDWIDTH; j++) begin
         sum = sum + prod_ext[j];
      end
   end

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: y = W*x in signed Q-format for a runtime-sized matrix.
// The vector is loaded in BANDWIDTH-wide chunks, W is fetched chunk by chunk
// from an external loader, and one saturated result per row is emitted over a
// valid/ready handshake.
// Optional feature: define MATVEC_BIAS_EN to add a per-row bias (bias ports
// and bias storage); without it the result is the plain product.
module matvec_engine
   import matvec_pkg::*;
#(
   parameter int MAX_ROWS   = 64,
   parameter int MAX_COLS   = 64,
   parameter int BANDWIDTH  = 16,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 12
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   input  logic [$clog2(MAX_ROWS+1)-1:0]             num_rows,
   input  logic [$clog2(MAX_COLS+1)-1:0]             num_cols,
   input  logic                                      vector_write_enable,
   input  logic [$clog2(MAX_COLS)-1:0]               vector_base_addr,
   input  logic [BANDWIDTH*DATA_WIDTH-1:0]           vector_in,
   output logic [$clog2(MAX_ROWS*MAX_COLS)-1:0]      matrix_addr,
   output logic                                      matrix_enable,
   input  logic [BANDWIDTH*DATA_WIDTH-1:0]           matrix_data,
   input  logic                                      matrix_ready,
   output logic [DATA_WIDTH-1:0]                     result_out,
   output logic [$clog2(MAX_ROWS)-1:0]               result_row,
   output logic                                      result_valid,
   input  logic                                      result_ready,
   output logic                                      busy,
   output logic                                      done
`ifdef MATVEC_BIAS_EN
   ,
   input  logic                                      bias_write_enable,
   input  logic [$clog2(MAX_ROWS)-1:0]               bias_base_addr,
   input  logic [BANDWIDTH*DATA_WIDTH-1:0]           bias_in
`endif
);

   localparam int NR_W      = $clog2(MAX_ROWS + 1);
   localparam int NC_W      = $clog2(MAX_COLS + 1);
   localparam int VA_W      = $clog2(MAX_COLS);
   localparam int RA_W      = $clog2(MAX_ROWS);
   localparam int MA_W      = $clog2(MAX_ROWS * MAX_COLS);
   localparam int RB_W      = MA_W + 1;
   localparam int CI_W      = $clog2(MAX_COLS + BANDWIDTH + 1);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, MAX_COLS);

   state_t                       state;
   state_t                       state_next;

   logic [NR_W-1:0]              rows_q;
   logic [NC_W-1:0]              cols_q;
   logic [NC_W-1:0]              wr_cnt;
   logic [NC_W-1:0]              chunks;
   logic [CI_W-1:0]              col;
   logic [NR_W-1:0]              row;
   logic [RB_W-1:0]              row_base;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic                         done_set;

   logic signed [DATA_WIDTH-1:0] vector_mem [MAX_COLS];

   logic [BANDWIDTH*DATA_WIDTH-1:0] vec_lanes;
   logic [BANDWIDTH-1:0]            lane_mask;
   logic signed [ACC_WIDTH-1:0]     mac_sum;

   logic signed [SAT_W-1:0]      acc_wide;
   logic [DATA_WIDTH-1:0]        sat_val;

   logic start_ok;
   logic wr_fire;
   logic wr_last;
   logic fetch_fire;
   logic fetch_last;
   logic emit_fire;
   logic emit_last;

`ifdef MATVEC_BIAS_EN
   logic signed [DATA_WIDTH-1:0] bias_mem [MAX_ROWS];
   logic signed [DATA_WIDTH-1:0] bias_cur;
`endif

   // Event strobes shared by the FSM and the datapath.
   assign chunks     = NC_W'((int'(cols_q) + BANDWIDTH - 1) / BANDWIDTH);
   assign start_ok   = start && (num_rows != '0) && (num_cols != '0);
   assign wr_fire    = (state == LOAD_VEC) && vector_write_enable;
   assign wr_last    = wr_fire && (int'(wr_cnt) + 1 == int'(chunks));
   assign fetch_fire = (state == FETCH) && matrix_ready;
   assign fetch_last = fetch_fire && (int'(col) + BANDWIDTH >= int'(cols_q));
   assign emit_fire  = (state == EMIT) && result_ready;
   assign emit_last  = emit_fire && (int'(row) + 1 == int'(rows_q));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake/status outputs.
   always_comb begin
      state_next    = state;
      busy          = 1'b1;
      matrix_enable = 1'b0;
      result_valid  = 1'b0;
      done_set      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (start_ok) begin
                  state_next = LOAD_VEC;
               end else begin
                  done_set = 1'b1;
               end
            end
         end
         LOAD_VEC: begin
            if (wr_last) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            matrix_enable = 1'b1;
            if (fetch_last) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            result_valid = 1'b1;
            if (emit_fire) begin
               if (emit_last) begin
                  state_next = IDLE;
                  done_set   = 1'b1;
               end else begin
                  state_next = FETCH;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Counters, latched dimensions, accumulator and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_q   <= '0;
         cols_q   <= '0;
         wr_cnt   <= '0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
         acc      <= '0;
         done     <= 1'b0;
      end else begin
         done <= done_set;
         if ((state == IDLE) && start_ok) begin
            rows_q   <= num_rows;
            cols_q   <= num_cols;
            wr_cnt   <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            acc      <= '0;
         end
         if (wr_fire) begin
            wr_cnt <= wr_cnt + NC_W'(1);
         end
         if (wr_last) begin
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            acc      <= '0;
         end
         if (fetch_fire) begin
            acc <= acc + mac_sum;
            col <= col + CI_W'(BANDWIDTH);
         end
         if (emit_fire) begin
            col <= '0;
            acc <= '0;
            if (emit_last) begin
               row      <= '0;
               row_base <= '0;
            end else begin
               row      <= row + NR_W'(1);
               row_base <= row_base + RB_W'(cols_q);
            end
         end
      end
   end

   // Vector storage: lanes that would land past the end of storage are dropped.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int j = 0; j < BANDWIDTH; j++) begin
            if (int'(vector_base_addr) + j < MAX_COLS) begin
               vector_mem[VA_W'(int'(vector_base_addr) + j)] <=
                  signed'(vector_in[j*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      end
   end

`ifdef MATVEC_BIAS_EN
   // Bias storage, writable while no matrix traffic is in flight.
   always_ff @(posedge clk) begin
      if (bias_write_enable && ((state == IDLE) || (state == LOAD_VEC))) begin
         for (int j = 0; j < BANDWIDTH; j++) begin
            if (int'(bias_base_addr) + j < MAX_ROWS) begin
               bias_mem[RA_W'(int'(bias_base_addr) + j)] <=
                  signed'(bias_in[j*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
      end
   end
`endif

   // Vector lanes aligned to the current column, masked past the row end.
   always_comb begin
      vec_lanes = '0;
      lane_mask = '0;
      for (int j = 0; j < BANDWIDTH; j++) begin
         if (int'(col) + j < int'(cols_q)) begin
            lane_mask[j]                         = 1'b1;
            vec_lanes[j*DATA_WIDTH +: DATA_WIDTH] = vector_mem[VA_W'(int'(col) + j)];
         end
      end
   end

   matvec_chunk_mac #(
      .BANDWIDTH  (BANDWIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .matrix_lanes (matrix_data),
      .vector_lanes (vec_lanes),
      .lane_mask    (lane_mask),
      .sum          (mac_sum)
   );

   // Accumulator widened for rescaling, with the row bias added in product scale.
   always_comb begin
      acc_wide = {{(SAT_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
`ifdef MATVEC_BIAS_EN
      bias_cur = bias_mem[RA_W'(row)];
      acc_wide = acc_wide + ({{(SAT_W-DATA_WIDTH){bias_cur[DATA_WIDTH-1]}}, bias_cur} <<< FRAC_BITS);
`endif
   end

   // Arithmetic shift rounds toward minus infinity before clamping.
   assign sat_val      = DATA_WIDTH'(saturate(acc_wide >>> FRAC_BITS, DATA_WIDTH));
   assign result_out   = (state == EMIT) ? sat_val : '0;
   assign result_row   = RA_W'(row);
   assign matrix_addr  = (state == FETCH) ? MA_W'(int'(row_base) + int'(col)) : '0;

endmodule

// File: tb/tb_matvec_engine.sv
// Self-checking bench for matvec_engine (BANDWIDTH=4, Q4.12 operands).
// Builds with or without MATVEC_BIAS_EN.
module tb_matvec_engine;

   localparam int MR = 64;
   localparam int MC = 64;
   localparam int BW = 4;
   localparam int DW = 16;
   localparam int FB = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [6:0]    num_rows = '0;
   logic [6:0]    num_cols = '0;
   logic          vector_write_enable = 1'b0;
   logic [5:0]    vector_base_addr = '0;
   logic [BW*DW-1:0] vector_in = '0;
   logic [11:0]   matrix_addr;
   logic          matrix_enable;
   logic [BW*DW-1:0] matrix_data = '0;
   logic          matrix_ready = 1'b0;
   logic [DW-1:0] result_out;
   logic [5:0]    result_row;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic          busy;
   logic          done;
`ifdef MATVEC_BIAS_EN
   logic          bias_write_enable = 1'b0;
   logic [5:0]    bias_base_addr = '0;
   logic [BW*DW-1:0] bias_in = '0;
`endif

   matvec_engine #(
      .MAX_ROWS(MR), .MAX_COLS(MC), .BANDWIDTH(BW), .DATA_WIDTH(DW), .FRAC_BITS(FB)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
      .vector_write_enable(vector_write_enable), .vector_base_addr(vector_base_addr),
      .vector_in(vector_in), .matrix_addr(matrix_addr), .matrix_enable(matrix_enable),
      .matrix_data(matrix_data), .matrix_ready(matrix_ready), .result_out(result_out),
      .result_row(result_row), .result_valid(result_valid), .result_ready(result_ready),
      .busy(busy), .done(done)
`ifdef MATVEC_BIAS_EN
      , .bias_write_enable(bias_write_enable), .bias_base_addr(bias_base_addr), .bias_in(bias_in)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int wmem [4096];
   int xv   [64];
   int bv   [64];
   int cur_cols = 1;
   int max_wait = 0;
   int wcnt = 0;
   int ld_c;
   int addr_q [$];
   int got_v  [$];
   int got_r  [$];

   typedef struct {
      int rows;
      int cols;
      int kind;
      int e0;
      int e1;
      int e2;
      int e3;
   } vec_t;
   vec_t tbl [5];

   // Matrix loader: random wait states; lanes beyond the row end carry garbage.
   always @(negedge clk) begin
      if (matrix_ready) wcnt = $urandom_range(0, max_wait);
      matrix_ready = 1'b0;
      if (matrix_enable && !rst) begin
         if (wcnt == 0) begin
            matrix_ready = 1'b1;
            addr_q.push_back(int'(matrix_addr));
            for (int j = 0; j < BW; j++) begin
               ld_c = (int'(matrix_addr) % cur_cols) + j;
               if (ld_c < cur_cols) matrix_data[j*DW +: DW] = DW'(wmem[int'(matrix_addr) + j]);
               else                 matrix_data[j*DW +: DW] = DW'($urandom);
            end
         end else begin
            wcnt = wcnt - 1;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: y[r] = clamp(floor(sum W*x / 2^FB) + bias[r]).
   function automatic int model_row(input int r, input int cols);
      longint s = 0;
      longint q;
      for (int c = 0; c < cols; c++) s += longint'(wmem[r*cols + c]) * longint'(xv[c]);
      q = s / 4096;
      if ((s % 4096 != 0) && (s < 0)) q = q - 1;
      q = q + bv[r];
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   task automatic fill(input int kind, input int rows, input int cols);
      for (int r = 0; r < rows; r++)
         for (int c = 0; c < cols; c++) begin
            case (kind)
               0: wmem[r*cols + c] = 4*r + c;
               1: wmem[r*cols + c] = 32767;
               2: wmem[r*cols + c] = -32768;
               3: wmem[r*cols + c] = 4096 * (r + 1);
               4: wmem[r*cols + c] = -1;
               default: wmem[r*cols + c] = int'($urandom_range(0, 65535)) - 32768;
            endcase
         end
      for (int c = 0; c < cols; c++) begin
         case (kind)
            0: xv[c] = 4096 * (c + 1);
            1, 2: xv[c] = 32767;
            3: xv[c] = c + 1;
            4: xv[c] = 1;
            default: xv[c] = int'($urandom_range(0, 65535)) - 32768;
         endcase
      end
   endtask

   task automatic start_and_load(input int rows, input int cols);
      @(negedge clk);
      cur_cols = cols;
      num_rows = 7'(rows);
      num_cols = 7'(cols);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k * BW < cols; k++) begin
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         vector_write_enable = 1'b1;
         vector_base_addr = 6'(k * BW);
         for (int j = 0; j < BW; j++)
            vector_in[j*DW +: DW] = (k*BW + j < cols) ? DW'(xv[k*BW + j]) : DW'($urandom);
         @(negedge clk);
         vector_write_enable = 1'b0;
      end
   endtask

   task automatic collect(input int rows, input int bp_pct);
      int n = 0;
      int cyc = 0;
      got_v.delete();
      got_r.delete();
      while (n < rows && cyc < 3000) begin
         result_ready = ($urandom_range(0, 99) >= bp_pct);
         if (result_valid && result_ready) begin
            got_v.push_back(int'($signed(result_out)));
            got_r.push_back(int'(result_row));
            n++;
         end
         @(negedge clk);
         cyc++;
      end
      result_ready = 1'b0;
      if (n < rows) chk("timeout_results", n, rows);
      else begin
         chk("done_pulse", done, 1);
         chk("busy_low_at_done", busy, 0);
      end
   endtask

   task automatic run_table_entry(input int i);
      int ev [4];
      ev[0] = tbl[i].e0; ev[1] = tbl[i].e1; ev[2] = tbl[i].e2; ev[3] = tbl[i].e3;
      fill(tbl[i].kind, tbl[i].rows, tbl[i].cols);
      addr_q.delete();
      start_and_load(tbl[i].rows, tbl[i].cols);
      collect(tbl[i].rows, 25);
      for (int r = 0; r < tbl[i].rows && r < got_v.size(); r++) begin
         chk($sformatf("tbl%0d_val_r%0d", i, r), got_v[r], ev[r]);
         chk($sformatf("tbl%0d_row_r%0d", i, r), got_r[r], r);
      end
   endtask

   initial begin
      int v0;
      int r0;
      int exp_addr [4];
      int rows;
      int cols;
      int guard;

      for (int i = 0; i < 64; i++) bv[i] = 0;
      tbl[0] = '{rows:4, cols:4, kind:0, e0:20,     e1:60,     e2:100, e3:140};
      tbl[1] = '{rows:1, cols:4, kind:1, e0:32767,  e1:0,      e2:0,   e3:0};
      tbl[2] = '{rows:1, cols:4, kind:2, e0:-32768, e1:0,      e2:0,   e3:0};
      tbl[3] = '{rows:2, cols:5, kind:3, e0:15,     e1:30,     e2:0,   e3:0};
      tbl[4] = '{rows:1, cols:1, kind:4, e0:-1,     e1:0,      e2:0,   e3:0};

      // Reset values
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_matrix_enable", matrix_enable, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_result_out", result_out, 0);
      chk("rst_result_row", result_row, 0);
      chk("rst_matrix_addr", matrix_addr, 0);
      rst = 1'b0;

`ifdef MATVEC_BIAS_EN
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         bias_write_enable = 1'b1;
         bias_base_addr = 6'(k * BW);
         bias_in = '0;
      end
      @(negedge clk);
      bias_write_enable = 1'b0;
`endif

      // Zero dimension: immediate done, no operation
      @(negedge clk);
      num_rows = 7'd0; num_cols = 7'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero_dim_done", done, 1);
      chk("zero_dim_busy", busy, 0);
      @(negedge clk);
      chk("zero_dim_done_one_cycle", done, 0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         max_wait = i % 3;
         run_table_entry(i);
         if (i == 3) begin
            exp_addr[0] = 0; exp_addr[1] = 4; exp_addr[2] = 5; exp_addr[3] = 9;
            chk("addr_count", addr_q.size(), 4);
            for (int k = 0; k < 4 && k < addr_q.size(); k++)
               chk($sformatf("addr_seq_%0d", k), addr_q[k], exp_addr[k]);
         end
      end

      // Output backpressure: held result stays stable, no fetch during stall
      max_wait = 0;
      fill(0, 4, 4);
      start_and_load(4, 4);
      result_ready = 1'b0;
      guard = 0;
      while (!result_valid && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("bp_valid_seen", result_valid, 1);
      v0 = int'($signed(result_out));
      r0 = int'(result_row);
      chk("bp_first_val", v0, 20);
      chk("bp_first_row", r0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid_held", result_valid, 1);
         chk("bp_out_held", $signed(result_out), v0);
         chk("bp_row_held", result_row, r0);
         chk("bp_no_fetch", matrix_enable, 0);
      end
      collect(4, 0);
      for (int r = 0; r < 4 && r < got_v.size(); r++) begin
         chk($sformatf("bp_val_r%0d", r), got_v[r], 20 + 40 * r);
         chk($sformatf("bp_row_r%0d", r), got_r[r], r);
      end

      // Reset in the middle of a fetch, then a full operation
      max_wait = 6;
      fill(0, 4, 4);
      start_and_load(4, 4);
      guard = 0;
      while (!matrix_enable && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("midrst_in_fetch", matrix_enable, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_matrix_enable", matrix_enable, 0);
      chk("midrst_result_valid", result_valid, 0);
      chk("midrst_done", done, 0);
      chk("midrst_matrix_addr", matrix_addr, 0);
      chk("midrst_result_out", result_out, 0);
      chk("midrst_result_row", result_row, 0);
      rst = 1'b0;
      max_wait = 0;
      run_table_entry(0);

      // Randomized operations against the reference model
      for (int t = 0; t < 20; t++) begin
         rows = $urandom_range(1, 6);
         cols = $urandom_range(1, 13);
         max_wait = $urandom_range(0, 3);
         fill(9, rows, cols);
         start_and_load(rows, cols);
         collect(rows, 30);
         for (int r = 0; r < rows && r < got_v.size(); r++) begin
            chk($sformatf("rnd%0d_val_r%0d", t, r), got_v[r], model_row(r, cols));
            chk($sformatf("rnd%0d_row_r%0d", t, r), got_r[r], r);
         end
      end

`ifdef MATVEC_BIAS_EN
      // Bias on the ramp case
      @(negedge clk);
      bias_write_enable = 1'b1;
      bias_base_addr = 6'd0;
      bv[0] = 4096; bv[1] = 0; bv[2] = -4096; bv[3] = 0;
      for (int j = 0; j < BW; j++) bias_in[j*DW +: DW] = DW'(bv[j]);
      @(negedge clk);
      bias_write_enable = 1'b0;
      max_wait = 1;
      fill(0, 4, 4);
      start_and_load(4, 4);
      collect(4, 20);
      for (int r = 0; r < 4 && r < got_v.size(); r++)
         chk($sformatf("bias_val_r%0d", r), got_v[r], model_row(r, 4));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
